conv_compute: RTL and testbench

Consumer stage for the input memories of the 2D convolution accelerator. Once `inputs_loaded` is high, it walks every valid output position. For each position it reads the K×K window of X and the K×K weights from the two synchronous memories, multiply-accumulates them starting from B, and streams each Y value out over an AXI-Stream master port. After the final Y value is accepted it pulses `compute_finished`, which hands the memories back for the next load.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_addr_gen.sv | 104 ++++++++++
 rtl/conv_compute.sv | 118 +++++++++++
 tb/tb_conv_compute.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution accelerator.
// The input memory block uses these helpers too.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    LAST,
    EMIT,
    DONE
  } conv_state_t;

  function automatic int unsigned x_addr_bits(int unsigned rows, int unsigned cols);
    return $clog2(rows * cols);
  endfunction

  function automatic int unsigned w_addr_bits(int unsigned maxk);
    return $clog2(maxk * maxk);
  endfunction

  function automatic int unsigned k_bits(int unsigned maxk);
    return $clog2(maxk + 1);
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Output-position (r, c) and window (i, j) counters plus the X/W read address
// arithmetic. K is captured on start and held for the whole job.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned R    = 9,
  parameter int unsigned C    = 8,
  parameter int unsigned MAXK = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic [k_bits(MAXK)-1:0]      k_i,
  input  logic                         step_i,
  input  logic                         advance_i,
  input  logic                         addr_en_i,
  output logic [x_addr_bits(R,C)-1:0]  x_addr_o,
  output logic [w_addr_bits(MAXK)-1:0] w_addr_o,
  output logic                         window_last_o,
  output logic                         position_last_o
);

  localparam int unsigned KB = k_bits(MAXK);
  localparam int unsigned XB = x_addr_bits(R, C);
  localparam int unsigned WB = w_addr_bits(MAXK);
  localparam int unsigned RB = $clog2(R);
  localparam int unsigned CB = $clog2(C);

  logic [KB-1:0] k_q, k_d;
  logic [RB-1:0] r_q, r_d;
  logic [CB-1:0] c_q, c_d;
  logic [KB-1:0] i_q, i_d;
  logic [KB-1:0] j_q, j_d;

  int unsigned kk, rr, cc, ii, jj;

  always_comb begin
    kk = 32'(k_q);
    rr = 32'(r_q);
    cc = 32'(c_q);
    ii = 32'(i_q);
    jj = 32'(j_q);
    window_last_o   = (ii == kk - 1) && (jj == kk - 1);
    position_last_o = (rr == R - kk) && (cc == C - kk);
    x_addr_o = '0;
    w_addr_o = '0;
    if (addr_en_i) begin
      x_addr_o = XB'((rr + ii) * C + cc + jj);
      w_addr_o = WB'(ii * kk + jj);
    end
  end

  always_comb begin
    k_d = k_q;
    r_d = r_q;
    c_d = c_q;
    i_d = i_q;
    j_d = j_q;
    if (start_i) begin
      k_d = k_i;
      r_d = '0;
      c_d = '0;
      i_d = '0;
      j_d = '0;
    end else begin
      if (step_i) begin
        if (jj == kk - 1) begin
          j_d = '0;
          i_d = (ii == kk - 1) ? '0 : i_q + KB'(1);
        end else begin
          j_d = j_q + KB'(1);
        end
      end
      // Moving to the next position also rewinds the window.
      if (advance_i) begin
        i_d = '0;
        j_d = '0;
        if (cc == C - kk) begin
          c_d = '0;
          r_d = r_q + RB'(1);
        end else begin
          c_d = c_q + CB'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q <= '0;
      r_q <= '0;
      c_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end else begin
      k_q <= k_d;
      r_q <= r_d;
      c_q <= c_d;
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/conv_compute.sv
// Convolution consumer: walks every valid output position, multiply-accumulates
// the KxK window from the X/W memories onto B and streams Y over AXI-Stream.
module conv_compute
  import conv_pkg::*;
#(
  parameter int unsigned INW  = 24,
  parameter int unsigned OUTW = 52,
  parameter int unsigned R    = 9,
  parameter int unsigned C    = 8,
  parameter int unsigned MAXK = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inputs_loaded,
  output logic                         compute_finished,
  input  logic [k_bits(MAXK)-1:0]      K,
  input  logic [INW-1:0]               B,
  output logic [x_addr_bits(R,C)-1:0]  X_read_addr,
  input  logic [INW-1:0]               X_data,
  output logic [w_addr_bits(MAXK)-1:0] W_read_addr,
  input  logic [INW-1:0]               W_data,
  output logic [OUTW-1:0]              AXIS_TDATA,
  output logic                         AXIS_TVALID,
  input  logic                         AXIS_TREADY
);

  conv_state_t state_q, state_d;
  logic [OUTW-1:0] acc_q, acc_d;
  logic            rd_valid_q;

  logic signed [2*INW-1:0] x_ext, w_ext, prod;
  logic [OUTW-1:0]         prod_ext, b_ext;

  logic start, step, advance;
  logic window_last, position_last;

  assign x_ext    = {{INW{X_data[INW-1]}}, X_data};
  assign w_ext    = {{INW{W_data[INW-1]}}, W_data};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(OUTW-2*INW){prod[2*INW-1]}}, prod};
  assign b_ext    = {{(OUTW-INW){B[INW-1]}}, B};

  conv_addr_gen #(
    .R    (R),
    .C    (C),
    .MAXK (MAXK)
  ) u_addr_gen (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start),
    .k_i             (K),
    .step_i          (step),
    .advance_i       (advance),
    .addr_en_i       (state_q == ISSUE),
    .x_addr_o        (X_read_addr),
    .w_addr_o        (W_read_addr),
    .window_last_o   (window_last),
    .position_last_o (position_last)
  );

  // Memory data lags its address by one cycle; rd_valid_q marks cycles whose
  // data belongs to an address issued in the previous ISSUE cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    start   = 1'b0;
    step    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (inputs_loaded) begin
          acc_d   = b_ext;
          start   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        step = 1'b1;
        if (rd_valid_q) acc_d = acc_q + prod_ext;
        if (window_last) state_d = LAST;
      end
      LAST: begin
        acc_d   = acc_q + prod_ext;
        state_d = EMIT;
      end
      EMIT: begin
        if (AXIS_TREADY) begin
          if (position_last) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            acc_d   = b_ext;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rd_valid_q <= (state_q == ISSUE);
    end
  end

  assign AXIS_TVALID      = (state_q == EMIT);
  assign AXIS_TDATA       = acc_q;
  assign compute_finished = (state_q == DONE);

endmodule

// File: tb/tb_conv_compute.sv
// Scoreboard bench for conv_compute: a convolution reference model fills the
// expected queue; a monitor pops and compares on every AXI-Stream handshake.
`timescale 1ns/1ps
module tb_conv_compute;

  localparam int INW  = 24;
  localparam int OUTW = 52;
  localparam int R    = 9;
  localparam int C    = 8;
  localparam int MAXK = 4;
  localparam int XB   = $clog2(R*C);
  localparam int WB   = $clog2(MAXK*MAXK);
  localparam int KB   = $clog2(MAXK+1);

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            inputs_loaded = 1'b0;
  logic            compute_finished;
  logic [KB-1:0]   K = '0;
  logic [INW-1:0]  B = '0;
  logic [XB-1:0]   X_read_addr;
  logic [INW-1:0]  X_data = '0;
  logic [WB-1:0]   W_read_addr;
  logic [INW-1:0]  W_data = '0;
  logic [OUTW-1:0] AXIS_TDATA;
  logic            AXIS_TVALID;
  logic            AXIS_TREADY = 1'b1;

  logic signed [INW-1:0] xm [R*C];
  logic signed [INW-1:0] wm [MAXK*MAXK];

  logic [OUTW-1:0] exp_q [$];
  int              hs_cyc [$];
  int              fin_cyc [$];
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  bit              rdy_rand = 1'b0;

  conv_compute #(
    .INW  (INW),
    .OUTW (OUTW),
    .R    (R),
    .C    (C),
    .MAXK (MAXK)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .inputs_loaded    (inputs_loaded),
    .compute_finished (compute_finished),
    .K                (K),
    .B                (B),
    .X_read_addr      (X_read_addr),
    .X_data           (X_data),
    .W_read_addr      (W_read_addr),
    .W_data           (W_data),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TVALID      (AXIS_TVALID),
    .AXIS_TREADY      (AXIS_TREADY)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Synchronous memories with one-cycle registered read.
  always @(posedge clk) begin
    X_data <= xm[X_read_addr];
    W_data <= wm[W_read_addr];
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      AXIS_TREADY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops, AXIS hold/stability and finish pulse width.
  initial begin
    logic            pv;
    logic            phs;
    logic            pfin;
    logic [OUTW-1:0] pd;
    pv = 1'b0; phs = 1'b0; pfin = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pv = 1'b0; phs = 1'b0; pfin = 1'b0;
      end else begin
        if (pv && !phs) begin
          check("tvalid_held", 64'(AXIS_TVALID), 64'd1);
          check("tdata_stable", 64'(AXIS_TDATA), 64'(pd));
        end
        if (AXIS_TVALID && AXIS_TREADY) begin
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h expected no output", AXIS_TDATA);
          end else begin
            check("tdata", 64'(AXIS_TDATA), 64'(exp_q.pop_front()));
          end
        end
        if (compute_finished) begin
          fin_cyc.push_back(cyc);
          check("finish_pulse_width", 64'(pfin), 64'd0);
        end
        pv   = AXIS_TVALID;
        pd   = AXIS_TDATA;
        phs  = AXIS_TVALID && AXIS_TREADY;
        pfin = compute_finished;
      end
    end
  end

  // Reference convolution over the memory images, wrapped to OUTW bits.
  task automatic push_model(input int k, input longint b, output int n);
    longint y;
    n = 0;
    for (int r = 0; r <= R - k; r++) begin
      for (int c = 0; c <= C - k; c++) begin
        y = b;
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            y += longint'(xm[(r+i)*C + c + j]) * longint'(wm[i*k + j]);
        exp_q.push_back(y[OUTW-1:0]);
        n++;
      end
    end
  endtask

  task automatic run_job(input int k, input longint b, input bit timing);
    int n;
    int start;
    int budget;
    bit done;
    push_model(k, b, n);
    hs_cyc.delete();
    fin_cyc.delete();
    @(negedge clk);
    K = KB'(k);
    B = INW'(b);
    inputs_loaded = 1'b1;
    start = cyc;
    budget = n * (k*k + 2) * 6 + 200;
    done = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (compute_finished) begin
        done = 1'b1;
        break;
      end
    end
    inputs_loaded = 1'b0;
    check("job_done_in_budget", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    check("output_count", 64'(hs_cyc.size()), 64'(n));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("finish_count", 64'(fin_cyc.size()), 64'd1);
    if (hs_cyc.size() > 0 && fin_cyc.size() > 0)
      check("finish_after_last_hs", 64'(fin_cyc[0] - hs_cyc[$]), 64'd1);
    if (timing && hs_cyc.size() == n) begin
      check("first_tvalid_latency", 64'(hs_cyc[0] - start), 64'(k*k + 2));
      for (int i = 1; i < n; i++)
        check("hs_interval", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(k*k + 2));
    end
    exp_q.delete();
  endtask

  task automatic fill_random();
    for (int n = 0; n < R*C; n++) xm[n] = INW'($urandom);
    for (int n = 0; n < MAXK*MAXK; n++) wm[n] = INW'($urandom);
    xm[0]  = {1'b1, {(INW-1){1'b0}}};
    xm[10] = {1'b1, {(INW-1){1'b0}}};
    wm[0]  = {1'b1, {(INW-1){1'b0}}};
    wm[5]  = {1'b1, {(INW-1){1'b0}}};
  endtask

  initial begin
    logic signed [INW-1:0] bs, bs2;
    int n_rst;
    bit seen;

    for (int n = 0; n < R*C; n++) xm[n] = '0;
    for (int n = 0; n < MAXK*MAXK; n++) wm[n] = '0;

    repeat (3) @(negedge clk);
    check("reset_tvalid", 64'(AXIS_TVALID), 64'd0);
    check("reset_tdata", 64'(AXIS_TDATA), 64'd0);
    check("reset_finished", 64'(compute_finished), 64'd0);
    check("reset_xaddr", 64'(X_read_addr), 64'd0);
    check("reset_waddr", 64'(W_read_addr), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // All ones, K=3, B=5
    for (int n = 0; n < R*C; n++) xm[n] = 1;
    for (int n = 0; n < MAXK*MAXK; n++) wm[n] = 1;
    run_job(3, 64'sd5, 1'b1);

    // K=1, X[n]=n, W[0]=2, B=-1
    for (int n = 0; n < R*C; n++) xm[n] = INW'(n);
    wm[0] = 2;
    run_job(1, -64'sd1, 1'b1);

    // K=4 random signed data, then the same job with random back-pressure
    fill_random();
    bs = INW'($urandom);
    run_job(4, longint'(bs), 1'b1);
    rdy_rand = 1'b1;
    run_job(4, longint'(bs), 1'b0);
    rdy_rand = 1'b0;

    // Reset during the fifth output's window
    fill_random();
    bs = INW'($urandom);
    push_model(3, longint'(bs), n_rst);
    hs_cyc.delete();
    @(negedge clk);
    K = KB'(3);
    B = bs;
    inputs_loaded = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (hs_cyc.size() >= 4) begin
        seen = 1'b1;
        break;
      end
    end
    check("four_outputs_before_reset", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_tvalid", 64'(AXIS_TVALID), 64'd0);
    check("midrst_finished", 64'(compute_finished), 64'd0);
    check("midrst_tdata", 64'(AXIS_TDATA), 64'd0);
    inputs_loaded = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_job(3, longint'(bs), 1'b1);

    // Back-to-back jobs with new K and B
    fill_random();
    bs  = INW'($urandom);
    bs2 = INW'($urandom);
    run_job(3, longint'(bs), 1'b1);
    run_job(2, longint'(bs2), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
